rs_alu_station: RTL and testbench

Reservation station feeding the ALU execution unit in the Tomasulo pipeline. Accepts issued ALU instructions from the issue/rename stage and holds them in NUM_ENTRIES slots. Snoops the CDB to capture pending operands, and dispatches the oldest fully-ready entry to the ALU unit, whose result FIFO write enable is driven by disp_en_o.

---
 rtl/rs_alu_station.sv | 196 +++++++++++++++++++
 tb/tb_rs_alu_station.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_alu_station.sv
// ALU reservation station: holds issued ALU ops, snoops the CDB for pending
// operands and dispatches the oldest ready entry to the ALU result FIFO.
module rs_alu_station #(
  parameter int XLEN        = 32,
  parameter int TAG_W       = 4,
  parameter int OP_W        = 4,
  parameter int NUM_ENTRIES = 4,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [OP_W-1:0]  issue_op_i,
  input  logic [TAG_W-1:0] issue_tag_i,
  input  logic [XLEN-1:0]  issue_v1_i,
  input  logic [TAG_W-1:0] issue_q1_i,
  input  logic             issue_p1_i,
  input  logic [XLEN-1:0]  issue_v2_i,
  input  logic [TAG_W-1:0] issue_q2_i,
  input  logic             issue_p2_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [XLEN-1:0]  cdb_value_i,
  input  logic             alu_fifo_full_i,
  output logic             disp_en_o,
  output logic [OP_W-1:0]  disp_op_o,
  output logic [TAG_W-1:0] disp_tag_o,
  output logic [XLEN-1:0]  disp_v1_o,
  output logic [XLEN-1:0]  disp_v2_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int N = NUM_ENTRIES;

  logic [N-1:0]       busy_q, busy_d, p1_q, p1_d, p2_q, p2_d;
  logic [OP_W-1:0]    op_q  [N];
  logic [OP_W-1:0]    op_d  [N];
  logic [TAG_W-1:0]   tag_q [N];
  logic [TAG_W-1:0]   tag_d [N];
  logic [TAG_W-1:0]   q1_q  [N];
  logic [TAG_W-1:0]   q1_d  [N];
  logic [TAG_W-1:0]   q2_q  [N];
  logic [TAG_W-1:0]   q2_d  [N];
  logic [XLEN-1:0]    v1_q  [N];
  logic [XLEN-1:0]    v1_d  [N];
  logic [XLEN-1:0]    v2_q  [N];
  logic [XLEN-1:0]    v2_d  [N];
  // age_q[i][j] = 1 means entry i is older than entry j
  logic [N-1:0]       age_q [N];
  logic [N-1:0]       age_d [N];
  logic [CNT_W-1:0]   count_q, count_d;

  logic [N-1:0] ready, sel, alloc;
  logic         full, issue_fire, disp_en;

  always_comb begin
    ready = busy_q & ~p1_q & ~p2_q;
    sel   = '0;
    alloc = '0;
    for (int i = 0; i < N; i++) begin
      sel[i] = ready[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && ready[j] && age_q[j][i]) sel[i] = 1'b0;
      end
    end
    // Descending scan so the lowest free index is the one left standing
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc    = '0;
        alloc[i] = 1'b1;
      end
    end
  end

  assign full          = &busy_q;
  assign issue_ready_o = !full && !stall_i && !flush_i;
  assign issue_fire    = issue_valid_i && issue_ready_o;
  assign disp_en       = (|ready) && !alu_fifo_full_i && !stall_i && !flush_i;
  assign disp_en_o     = disp_en;
  assign count_o       = count_q;

  always_comb begin
    disp_op_o  = '0;
    disp_tag_o = '0;
    disp_v1_o  = '0;
    disp_v2_o  = '0;
    for (int i = 0; i < N; i++) begin
      if (disp_en && sel[i]) begin
        disp_op_o  = op_q[i];
        disp_tag_o = tag_q[i];
        disp_v1_o  = v1_q[i];
        disp_v2_o  = v2_q[i];
      end
    end
  end

  always_comb begin
    busy_d  = busy_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    count_d = count_q;
    for (int i = 0; i < N; i++) begin
      op_d[i]  = op_q[i];
      tag_d[i] = tag_q[i];
      q1_d[i]  = q1_q[i];
      q2_d[i]  = q2_q[i];
      v1_d[i]  = v1_q[i];
      v2_d[i]  = v2_q[i];
      age_d[i] = age_q[i];
    end

    for (int i = 0; i < N; i++) begin
      if (cdb_valid_i && busy_q[i] && p1_q[i] && q1_q[i] == cdb_tag_i) begin
        v1_d[i] = cdb_value_i;
        p1_d[i] = 1'b0;
      end
      if (cdb_valid_i && busy_q[i] && p2_q[i] && q2_q[i] == cdb_tag_i) begin
        v2_d[i] = cdb_value_i;
        p2_d[i] = 1'b0;
      end
      if (issue_fire && alloc[i]) begin
        busy_d[i] = 1'b1;
        op_d[i]   = issue_op_i;
        tag_d[i]  = issue_tag_i;
        q1_d[i]   = issue_q1_i;
        q2_d[i]   = issue_q2_i;
        // A broadcast in the issue cycle resolves the operand immediately
        if (issue_p1_i && !(cdb_valid_i && cdb_tag_i == issue_q1_i)) begin
          p1_d[i] = 1'b1;
          v1_d[i] = issue_v1_i;
        end else begin
          p1_d[i] = 1'b0;
          v1_d[i] = issue_p1_i ? cdb_value_i : issue_v1_i;
        end
        if (issue_p2_i && !(cdb_valid_i && cdb_tag_i == issue_q2_i)) begin
          p2_d[i] = 1'b1;
          v2_d[i] = issue_v2_i;
        end else begin
          p2_d[i] = 1'b0;
          v2_d[i] = issue_p2_i ? cdb_value_i : issue_v2_i;
        end
        age_d[i] = '0;
        for (int j = 0; j < N; j++) age_d[j][i] = busy_q[j];
      end
    end

    for (int i = 0; i < N; i++) begin
      if (disp_en && sel[i]) begin
        busy_d[i] = 1'b0;
        age_d[i]  = '0;
        for (int j = 0; j < N; j++) age_d[j][i] = 1'b0;
      end
    end

    count_d = count_q + CNT_W'(issue_fire) - CNT_W'(disp_en);

    if (flush_i) begin
      busy_d  = '0;
      p1_d    = '0;
      p2_d    = '0;
      count_d = '0;
      for (int i = 0; i < N; i++) age_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < N; i++) age_q[i] <= '0;
    end else begin
      busy_q  <= busy_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      count_q <= count_d;
      for (int i = 0; i < N; i++) age_q[i] <= age_d[i];
    end
  end

  // Payload fields are qualified by busy/pending bits, so they need no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      op_q[i]  <= op_d[i];
      tag_q[i] <= tag_d[i];
      q1_q[i]  <= q1_d[i];
      q2_q[i]  <= q2_d[i];
      v1_q[i]  <= v1_d[i];
      v2_q[i]  <= v2_d[i];
    end
  end

endmodule

// File: tb/tb_rs_alu_station.sv
// Bench for rs_alu_station: scoreboard of expected dispatches plus
// directed sequences for wakeup, bypass, full, stall and flush.
module tb_rs_alu_station;
  logic        clk = 1'b0;
  logic        rst, stall_i, flush_i;
  logic        issue_valid_i, issue_ready_o;
  logic [3:0]  issue_op_i, issue_tag_i, issue_q1_i, issue_q2_i;
  logic [31:0] issue_v1_i, issue_v2_i;
  logic        issue_p1_i, issue_p2_i;
  logic        cdb_valid_i;
  logic [3:0]  cdb_tag_i;
  logic [31:0] cdb_value_i;
  logic        alu_fifo_full_i;
  logic        disp_en_o;
  logic [3:0]  disp_op_o, disp_tag_o;
  logic [31:0] disp_v1_o, disp_v2_o;
  logic [2:0]  count_o;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  tag;
    logic [31:0] v1;
    logic [31:0] v2;
  } vec_t;

  vec_t sb[$];
  vec_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  rs_alu_station dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_op_i(issue_op_i), .issue_tag_i(issue_tag_i),
    .issue_v1_i(issue_v1_i), .issue_q1_i(issue_q1_i), .issue_p1_i(issue_p1_i),
    .issue_v2_i(issue_v2_i), .issue_q2_i(issue_q2_i), .issue_p2_i(issue_p2_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_value_i(cdb_value_i),
    .alu_fifo_full_i(alu_fifo_full_i),
    .disp_en_o(disp_en_o), .disp_op_o(disp_op_o), .disp_tag_o(disp_tag_o),
    .disp_v1_o(disp_v1_o), .disp_v2_o(disp_v2_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid_i = 1'b0;
    issue_p1_i    = 1'b0;
    issue_p2_i    = 1'b0;
    cdb_valid_i   = 1'b0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] tag,
                       input logic [31:0] v1, input logic [3:0] q1, input logic p1,
                       input logic [31:0] v2, input logic [3:0] q2, input logic p2);
    issue_valid_i = 1'b1;
    issue_op_i    = op;
    issue_tag_i   = tag;
    issue_v1_i    = v1;
    issue_q1_i    = q1;
    issue_p1_i    = p1;
    issue_v2_i    = v2;
    issue_q2_i    = q2;
    issue_p2_i    = p2;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid_i = 1'b1;
    cdb_tag_i   = tag;
    cdb_value_i = val;
  endtask

  task automatic push(input logic [3:0] op, input logic [3:0] tag,
                      input logic [31:0] v1, input logic [31:0] v2);
    vec_t e;
    e.op = op; e.tag = tag; e.v1 = v1; e.v2 = v2;
    sb.push_back(e);
  endtask

  // Every dispatch must match the next expected entry; idle outputs must be 0
  always @(negedge clk) begin
    if (!rst) begin
      if (disp_en_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_dispatch_tag", {124'd0, disp_tag_o}, 128'hFFFF);
        end else begin
          mon_e = sb.pop_front();
          chk("dispatch_fields", {56'd0, disp_op_o, disp_tag_o, disp_v1_o, disp_v2_o},
              {56'd0, mon_e.op, mon_e.tag, mon_e.v1, mon_e.v2});
        end
      end else begin
        chk("idle_outputs_zero", {56'd0, disp_op_o, disp_tag_o, disp_v1_o, disp_v2_o}, 128'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[8];
    int   idx;
    int   guard;
    logic accepted;

    tv[0] = '{op: 4'h1, tag: 4'h0, v1: 32'h0000_0001, v2: 32'h0000_0002};
    tv[1] = '{op: 4'h2, tag: 4'h7, v1: 32'hFFFF_FFFF, v2: 32'h0000_0000};
    tv[2] = '{op: 4'h3, tag: 4'hF, v1: 32'h8000_0000, v2: 32'h7FFF_FFFF};
    tv[3] = '{op: 4'hF, tag: 4'h2, v1: 32'hDEAD_BEEF, v2: 32'hCAFE_F00D};
    tv[4] = '{op: 4'h4, tag: 4'h5, v1: 32'h1234_5678, v2: 32'h9ABC_DEF0};
    tv[5] = '{op: 4'h0, tag: 4'hA, v1: 32'h0000_00FF, v2: 32'hFF00_0000};
    tv[6] = '{op: 4'h9, tag: 4'h4, v1: 32'h5555_5555, v2: 32'hAAAA_AAAA};
    tv[7] = '{op: 4'h6, tag: 4'hC, v1: 32'h0F0F_0F0F, v2: 32'hF0F0_F0F0};

    rst = 1'b1;
    alu_fifo_full_i = 1'b0;
    issue_op_i = '0; issue_tag_i = '0; issue_v1_i = '0; issue_v2_i = '0;
    issue_q1_i = '0; issue_q2_i = '0; cdb_tag_i = '0; cdb_value_i = '0;
    idle();
    repeat (2) step();
    probe();
    chk("rst_count", count_o, 0);
    chk("rst_disp_en", disp_en_o, 0);
    chk("rst_issue_ready", issue_ready_o, 1);
    step();
    rst = 1'b0;

    // Ready issue dispatches the next cycle
    issue(4'h0, 4'd3, 32'd5, 4'd0, 1'b0, 32'd7, 4'd0, 1'b0);
    probe(); chk("t1_issue_ready", issue_ready_o, 1);
    step(); push(4'h0, 4'd3, 32'd5, 32'd7); idle();
    probe(); chk("t1_disp_en", disp_en_o, 1); chk("t1_disp_tag", disp_tag_o, 3);
    chk("t1_count", count_o, 1);
    step();
    probe(); chk("t1_count_after", count_o, 0); chk("t1_disp_after", disp_en_o, 0);
    step();

    // Wakeup through CDB two cycles after issue
    issue(4'h2, 4'd1, 32'hDEAD, 4'd2, 1'b1, 32'd9, 4'd0, 1'b0);
    step(); push(4'h2, 4'd1, 32'h10, 32'd9); idle();
    probe(); chk("t2_wait1", disp_en_o, 0);
    step(); cdb(4'd2, 32'h10);
    probe(); chk("t2_bcast_cycle", disp_en_o, 0);
    step(); idle();
    probe(); chk("t2_disp_en", disp_en_o, 1); chk("t2_v1", disp_v1_o, 32'h10);
    chk("t2_v2", disp_v2_o, 9);
    step();

    // Issue-cycle bypass
    issue(4'h5, 4'd6, 32'd1, 4'd0, 1'b0, 32'd0, 4'd4, 1'b1);
    cdb(4'd4, 32'hAB);
    step(); push(4'h5, 4'd6, 32'd1, 32'hAB); idle();
    probe(); chk("t3_disp_en", disp_en_o, 1); chk("t3_v2", disp_v2_o, 32'hAB);
    step();

    // Fill, wake all with one broadcast, drain in age order
    for (int k = 0; k < 4; k++) begin
      issue(4'h1, 4'(8 + k), 32'd0, 4'd5, 1'b1, 32'h100 + k, 4'd0, 1'b0);
      step(); push(4'h1, 4'(8 + k), 32'h55, 32'h100 + k);
    end
    idle();
    probe(); chk("t4_count_full", count_o, 4); chk("t4_not_ready", issue_ready_o, 0);
    chk("t4_no_disp", disp_en_o, 0);
    step(); cdb(4'd5, 32'h55);
    probe(); chk("t4_bcast_cycle", disp_en_o, 0);
    step(); idle();
    for (int k = 0; k < 4; k++) begin
      probe();
      chk("t4_disp_en", disp_en_o, 1);
      chk("t4_order_tag", disp_tag_o, 8 + k);
      if (k == 0) chk("t4_ready_same_cycle", issue_ready_o, 0);
      if (k == 1) chk("t4_ready_next_cycle", issue_ready_o, 1);
      step();
    end
    probe(); chk("t4_empty", disp_en_o, 0); chk("t4_count0", count_o, 0);
    step();

    // FIFO-full hold, then stall hold, then release
    alu_fifo_full_i = 1'b1;
    issue(4'h3, 4'd12, 32'h12, 4'd0, 1'b0, 32'h34, 4'd0, 1'b0);
    step(); push(4'h3, 4'd12, 32'h12, 32'h34); idle();
    for (int k = 0; k < 3; k++) begin
      probe(); chk("t5_full_hold", disp_en_o, 0); chk("t5_full_count", count_o, 1);
      step();
    end
    alu_fifo_full_i = 1'b0; stall_i = 1'b1;
    probe(); chk("t5_stall_hold", disp_en_o, 0); chk("t5_stall_not_ready", issue_ready_o, 0);
    step(); stall_i = 1'b0;
    probe(); chk("t5_release", disp_en_o, 1); chk("t5_tag", disp_tag_o, 12);
    step();
    probe(); chk("t5_count0", count_o, 0);
    step();

    // Flush beats a simultaneous issue
    for (int k = 0; k < 3; k++) begin
      issue(4'h6, 4'(k), 32'd0, 4'd7, 1'b1, 32'd0, 4'd0, 1'b0);
      step();
    end
    idle(); flush_i = 1'b1;
    issue(4'h0, 4'd13, 32'd1, 4'd0, 1'b0, 32'd2, 4'd0, 1'b0);
    probe(); chk("t6_count3", count_o, 3); chk("t6_flush_not_ready", issue_ready_o, 0);
    step(); flush_i = 1'b0;
    issue(4'h7, 4'd14, 32'h14, 4'd0, 1'b0, 32'h41, 4'd0, 1'b0);
    probe(); chk("t6_count_flushed", count_o, 0); chk("t6_no_disp", disp_en_o, 0);
    chk("t6_ready_after", issue_ready_o, 1);
    step(); push(4'h7, 4'd14, 32'h14, 32'h41); idle();
    probe(); chk("t6_count1", count_o, 1); chk("t6_disp_tag", disp_tag_o, 14);
    step(); cdb(4'd7, 32'h77);
    probe();
    step(); idle();
    probe(); chk("t6_stale_gone", disp_en_o, 0); chk("t6_count_end", count_o, 0);
    step();

    // Table vectors: fill while FIFO is full, then refill slots as they drain
    alu_fifo_full_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue(tv[k].op, tv[k].tag, tv[k].v1, 4'd0, 1'b0, tv[k].v2, 4'd0, 1'b0);
      probe(); chk("tbl_fill_ready", issue_ready_o, 1);
      step(); push(tv[k].op, tv[k].tag, tv[k].v1, tv[k].v2);
    end
    alu_fifo_full_i = 1'b0;
    idx = 4; guard = 0;
    while (idx < 8 && guard < 50) begin
      issue(tv[idx].op, tv[idx].tag, tv[idx].v1, 4'd0, 1'b0, tv[idx].v2, 4'd0, 1'b0);
      probe(); accepted = issue_ready_o;
      step();
      if (accepted) begin
        push(tv[idx].op, tv[idx].tag, tv[idx].v1, tv[idx].v2);
        idx++;
      end
      guard++;
    end
    chk("tbl_all_issued", idx, 8);
    idle();
    guard = 0;
    while (count_o != 0 && guard < 50) begin
      step();
      guard++;
    end
    chk("tbl_drain_count", count_o, 0);
    probe();
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
